vga_scan: RTL and testbench

Raster initiator and pixel compositor for the game display. It generates the pixel coordinates `col`/`row` that every sprite block (kid, apples, spikes, tiles) decodes. It collects their coverage flags and colours one ROM-latency later, and drives the VGA pins with the highest-priority opaque layer. It also emits a once-per-frame tick that the game logic uses as its update strobe.

---
 rtl/vga_scan.sv | 110 +++++++++++
 tb/tb_vga_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan.sv
// Raster timing generator and two-stage pixel compositor for the VGA output.
// Emits col/row for the sprite blocks, merges their colours one cycle later and registers the pins.
module vga_scan #(
    parameter int H_VIS    = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_VIS    = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  col,
    output logic [9:0]  row,
    input  logic        is_kid,
    input  logic [11:0] kid_rgb,
    input  logic        is_apple,
    input  logic [11:0] apple_rgb,
    input  logic [11:0] bg_rgb,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        de,
    output logic        frame_tick
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
    localparam logic [10:0] H_VIS_C = 11'(H_VIS);
    localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0]  V_VIS_C = 10'(V_VIS);
    localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC);

    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        visible, hs_raw, vs_raw;
    logic        vis1_q, hs1_q, vs1_q;
    logic [11:0] rgb_q, rgb_d;
    logic        de_q, hs_q, vs_q, tick_q, tick_d;

    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    assign visible = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    assign hs_raw  = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_raw  = (v_q >= VS_BEG) && (v_q < VS_END);
    assign col     = visible ? h_q[9:0] : '0;
    assign row     = visible ? v_q : '0;
    // Counters sit at (0, V_VIS) right after the last visible pixel has left stage 0.
    assign tick_d  = (h_q == '0) && (v_q == V_VIS_C);

    // Sprite data arriving now belongs to the coordinates held in stage 1.
    always_comb begin
        rgb_d = 12'h000;
        if (vis1_q) begin
            if (is_kid)        rgb_d = kid_rgb;
            else if (is_apple) rgb_d = apple_rgb;
            else               rgb_d = bg_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q    <= '0;
            v_q    <= '0;
            vis1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            rgb_q  <= 12'h000;
            de_q   <= 1'b0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            tick_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            vis1_q <= visible;
            hs1_q  <= hs_raw;
            vs1_q  <= vs_raw;
            rgb_q  <= rgb_d;
            de_q   <= vis1_q;
            hs_q   <= ~(hs1_q ^ SYNC_POL);
            vs_q   <= ~(vs1_q ^ SYNC_POL);
            tick_q <= tick_d;
        end
    end

    assign r          = rgb_q[11:8];
    assign g          = rgb_q[7:4];
    assign b          = rgb_q[3:0];
    assign de         = de_q;
    assign hs         = hs_q;
    assign vs         = vs_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan using a shrunk raster (25x11 totals) so whole frames run quickly.
module tb_vga_scan;
    localparam int HV = 16, HF = 3, HS = 4, HB = 2;
    localparam int VV = 6,  VF = 2, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;   // 25
    localparam int VT = VV + VF + VS + VB;   // 11
    localparam int FT = HT * VT;             // 275

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  col, row;
    logic        is_kid, is_apple;
    logic [11:0] kid_rgb, apple_rgb, bg_rgb;
    logic        hs, vs, de, frame_tick;
    logic [3:0]  r, g, b;

    int checks = 0;
    int passed = 0;
    int n = 0;   // samples since the first cycle with rst high

    always #5 clk = ~clk;

    vga_scan #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .is_kid(is_kid), .kid_rgb(kid_rgb), .is_apple(is_apple),
        .apple_rgb(apple_rgb), .bg_rgb(bg_rgb),
        .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .de(de), .frame_tick(frame_tick)
    );

    // Expected values indexed by sample n; pins lag the counters by two samples.
    function automatic bit vis_at(int p);
        return (p >= 0) && ((p % HT) < HV) && (((p / HT) % VT) < VV);
    endfunction
    function automatic logic [9:0] exp_col(int p);
        return vis_at(p) ? 10'(p % HT) : 10'd0;
    endfunction
    function automatic logic [9:0] exp_row(int p);
        return vis_at(p) ? 10'((p / HT) % VT) : 10'd0;
    endfunction
    function automatic logic exp_hs(int p);
        return (p >= 0) && ((p % HT) >= HV + HF) && ((p % HT) < HV + HF + HS);
    endfunction
    function automatic logic exp_vs(int p);
        return (p >= 0) && (((p / HT) % VT) >= VV + VF) && (((p / HT) % VT) < VV + VF + VS);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({col, row, r, g, b, de, hs, vs, frame_tick} !== 36'd0)
                $display("FAIL reset_state cyc%0d: col=%0d row=%0d rgb=%h de=%b hs=%b vs=%b tick=%b, want all 0",
                         i, col, row, {r, g, b}, de, hs, vs, frame_tick);
            else passed++;
        end
        rst = 1'b1;
        n = 0;
    endtask

    task automatic test_line();
        for (int i = 0; i < 2 * HT; i++) begin
            checks++;
            if (col !== exp_col(n) || row !== exp_row(n))
                $display("FAIL line_coord n=%0d: col=%0d row=%0d, want %0d %0d", n, col, row, exp_col(n), exp_row(n));
            else passed++;
            checks++;
            if (de !== vis_at(n - 2) || {r, g, b} !== 12'h000)
                $display("FAIL line_de n=%0d: de=%b rgb=%h, want de=%b rgb=000", n, de, {r, g, b}, vis_at(n - 2));
            else passed++;
            step();
        end
    endtask

    task automatic test_priority();
        while (n < 2 * HT + 3) step();
        bg_rgb = 12'h00F;
        while (n < 2 * HT + 5) step();
        checks++;
        if (col !== 10'd5 || row !== 10'd2)
            $display("FAIL prio_coord: col=%0d row=%0d, want 5 2", col, row);
        else passed++;
        step();
        checks++;
        if ({r, g, b} !== 12'h00F) $display("FAIL prio_before: rgb=%h, want 00F", {r, g, b});
        else passed++;
        is_apple = 1'b1; apple_rgb = 12'hF00;
        step();
        checks++;
        if ({r, g, b} !== 12'hF00) $display("FAIL prio_apple: rgb=%h, want F00", {r, g, b});
        else passed++;
        is_apple = 1'b0;
        step();
        checks++;
        if ({r, g, b} !== 12'h00F) $display("FAIL prio_after: rgb=%h, want 00F", {r, g, b});
        else passed++;
        is_apple = 1'b1; is_kid = 1'b1; kid_rgb = 12'h0F0;
        step();
        checks++;
        if ({r, g, b} !== 12'h0F0) $display("FAIL prio_kid: rgb=%h, want 0F0", {r, g, b});
        else passed++;
        is_apple = 1'b0; is_kid = 1'b0;
        step();
        checks++;
        if ({r, g, b} !== 12'h00F) $display("FAIL prio_kid_after: rgb=%h, want 00F", {r, g, b});
        else passed++;
        bg_rgb = 12'h000;
    endtask

    task automatic test_sync();
        int ticks = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            checks++;
            if (hs !== exp_hs(n - 2) || vs !== exp_vs(n - 2) || de !== vis_at(n - 2))
                $display("FAIL sync n=%0d: hs=%b vs=%b de=%b, want %b %b %b",
                         n, hs, vs, de, exp_hs(n - 2), exp_vs(n - 2), vis_at(n - 2));
            else passed++;
            checks++;
            if (frame_tick !== ((n % FT) == VV * HT + 1))
                $display("FAIL tick n=%0d: frame_tick=%b, want %b", n, frame_tick, (n % FT) == VV * HT + 1);
            else passed++;
            if (frame_tick === 1'b1) ticks++;
            step();
        end
        checks++;
        if (ticks !== 2) $display("FAIL tick_count: got %0d ticks in two frames, want 2", ticks);
        else passed++;
    endtask

    task automatic test_blanking();
        is_kid = 1'b1; kid_rgb = 12'hFFF;
        step();
        step();
        for (int i = 0; i < FT; i++) begin
            checks++;
            if ({r, g, b} !== (vis_at(n - 2) ? 12'hFFF : 12'h000) || de !== vis_at(n - 2))
                $display("FAIL blank n=%0d: rgb=%h de=%b, want rgb=%h de=%b",
                         n, {r, g, b}, de, vis_at(n - 2) ? 12'hFFF : 12'h000, vis_at(n - 2));
            else passed++;
            step();
        end
    endtask

    task automatic test_wrap();
        while ((n % FT) != FT - 1) step();
        checks++;
        if (col !== 10'd0 || row !== 10'd0) $display("FAIL wrap_last: col=%0d row=%0d, want 0 0", col, row);
        else passed++;
        step();
        step();
        checks++;
        if (col !== 10'd1 || row !== 10'd0) $display("FAIL wrap_first: col=%0d row=%0d, want 1 0", col, row);
        else passed++;
        while ((n % FT) != HT + 1) step();
        checks++;
        if (col !== 10'd1 || row !== 10'd1) $display("FAIL wrap_line1: col=%0d row=%0d, want 1 1", col, row);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int ticks = 0;
        while ((n % FT) != 3 * HT + 4) step();
        checks++;
        if (col !== 10'd4 || row !== 10'd3 || de !== 1'b1)
            $display("FAIL mid_pre: col=%0d row=%0d de=%b, want 4 3 1", col, row, de);
        else passed++;
        rst = 1'b0;
        step();
        checks++;
        if ({col, row, r, g, b, de, hs, vs, frame_tick} !== 36'd0)
            $display("FAIL mid_reset_state: col=%0d row=%0d rgb=%h de=%b hs=%b vs=%b tick=%b, want all 0",
                     col, row, {r, g, b}, de, hs, vs, frame_tick);
        else passed++;
        rst = 1'b1;
        n = 0;
        while (n <= VV * HT + 2) begin
            checks++;
            if (col !== exp_col(n) || row !== exp_row(n) || de !== vis_at(n - 2))
                $display("FAIL mid_restart n=%0d: col=%0d row=%0d de=%b, want %0d %0d %b",
                         n, col, row, de, exp_col(n), exp_row(n), vis_at(n - 2));
            else passed++;
            checks++;
            if (frame_tick !== (n == VV * HT + 1))
                $display("FAIL mid_tick n=%0d: frame_tick=%b, want %b", n, frame_tick, n == VV * HT + 1);
            else passed++;
            if (frame_tick === 1'b1) ticks++;
            step();
        end
        checks++;
        if (ticks !== 1) $display("FAIL mid_tick_count: got %0d, want 1", ticks);
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        is_kid = 1'b0; is_apple = 1'b0;
        kid_rgb = 12'h000; apple_rgb = 12'h000; bg_rgb = 12'h000;
        #1;
        test_reset();
        test_line();
        test_priority();
        test_sync();
        test_blanking();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
